// File: rtl/cpu_pkg.sv
// Shared core constants used by the writeback path.
package cpu_pkg;
    localparam int XLEN  = 32;
    localparam int REG_W = 5;

    // x0 is hard-wired to zero, so it must never see a write enable.
    function automatic logic rf_writable(input logic [REG_W-1:0] idx);
        return idx != '0;
    endfunction
endpackage

// File: rtl/wb_fifo.sv
// Small in-order FIFO buffering ALU results ahead of the regfile write port.
module wb_fifo #(
    parameter  int W     = 37,
    parameter  int DEPTH = 2,
    localparam int AW    = $clog2(DEPTH),
    localparam int CW    = AW + 1
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          i_push,
    input  logic [W-1:0]  i_push_data,
    input  logic          i_pop,
    output logic [W-1:0]  o_pop_data,
    output logic [CW-1:0] o_count
);
    logic [W-1:0]  r_mem [DEPTH];
    logic [AW-1:0] r_wptr;
    logic [AW-1:0] r_rptr;
    logic [CW-1:0] r_count;

    // DEPTH is a power of two, so the pointers wrap on natural overflow.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
        end else begin
            if (i_push) r_wptr <= r_wptr + 1'b1;
            if (i_pop)  r_rptr <= r_rptr + 1'b1;
            case ({i_push, i_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (i_push) r_mem[r_wptr] <= i_push_data;
    end

    assign o_pop_data = r_mem[r_rptr];
    assign o_count    = r_count;
endmodule

// File: rtl/wb_arbiter.sv
// Writeback arbiter: merges buffered ALU results and load results onto one regfile write port.
module wb_arbiter #(
    parameter  int XLEN  = cpu_pkg::XLEN,
    parameter  int DEPTH = 2,
    localparam int RW    = cpu_pkg::REG_W,
    localparam int CW    = $clog2(DEPTH) + 1
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            alu_valid,
    output logic            alu_ready,
    input  logic [RW-1:0]   alu_rd,
    input  logic [XLEN-1:0] alu_data,
    input  logic            mem_valid,
    output logic            mem_ready,
    input  logic [RW-1:0]   mem_rd,
    input  logic [XLEN-1:0] mem_data,
    output logic [RW-1:0]   rd,
    output logic [XLEN-1:0] wd,
    output logic            we,
    output logic [CW-1:0]   fifo_count
);
    localparam logic [CW-1:0] FULL = CW'(DEPTH);

    logic [CW-1:0]      w_count;
    logic [RW+XLEN-1:0] w_head;
    logic               w_full;
    logic               w_push;
    logic               w_take_mem;
    logic               w_pop;

    logic [RW-1:0]      r_rd;
    logic [XLEN-1:0]    r_wd;
    logic               r_we;

    // A full FIFO always drains first so ALU results can never starve behind loads.
    assign w_full     = (w_count == FULL);
    assign w_push     = alu_valid && !w_full;
    assign w_take_mem = mem_valid && !w_full;
    assign w_pop      = w_full || (!mem_valid && w_count != '0);

    wb_fifo #(
        .W     (RW + XLEN),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk         (clk),
        .rst_n       (rst_n),
        .i_push      (w_push),
        .i_push_data ({alu_rd, alu_data}),
        .i_pop       (w_pop),
        .o_pop_data  (w_head),
        .o_count     (w_count)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_rd <= '0;
            r_wd <= '0;
            r_we <= 1'b0;
        end else if (w_take_mem) begin
            r_rd <= mem_rd;
            r_wd <= mem_data;
            r_we <= cpu_pkg::rf_writable(mem_rd);
        end else if (w_pop) begin
            r_rd <= w_head[RW+XLEN-1:XLEN];
            r_wd <= w_head[XLEN-1:0];
            r_we <= cpu_pkg::rf_writable(w_head[RW+XLEN-1:XLEN]);
        end else begin
            r_we <= 1'b0;
        end
    end

    assign alu_ready  = !w_full;
    assign mem_ready  = !w_full;
    assign rd         = r_rd;
    assign wd         = r_wd;
    assign we         = r_we;
    assign fifo_count = w_count;
endmodule

// File: tb/tb_wb_arbiter.sv
// Bench for wb_arbiter: queue-based reference model, per-cycle compare, directed and random stimulus.
module tb_wb_arbiter;
    localparam int XLEN  = 32;
    localparam int DEPTH = 2;
    localparam int CW    = $clog2(DEPTH) + 1;

    logic            clk = 1'b0;
    logic            rst_n = 1'b0;
    logic            alu_valid = 1'b0, mem_valid = 1'b0;
    logic            alu_ready, mem_ready;
    logic [4:0]      alu_rd = '0, mem_rd = '0;
    logic [XLEN-1:0] alu_data = '0, mem_data = '0;
    logic [4:0]      rd;
    logic [XLEN-1:0] wd;
    logic            we;
    logic [CW-1:0]   fifo_count;

    always #5 clk = ~clk;

    wb_arbiter #(.XLEN(XLEN), .DEPTH(DEPTH)) dut (
        .clk(clk), .rst_n(rst_n),
        .alu_valid(alu_valid), .alu_ready(alu_ready), .alu_rd(alu_rd), .alu_data(alu_data),
        .mem_valid(mem_valid), .mem_ready(mem_ready), .mem_rd(mem_rd), .mem_data(mem_data),
        .rd(rd), .wd(wd), .we(we), .fifo_count(fifo_count)
    );

    typedef struct packed { logic [4:0] rd; logic [31:0] d; } ent_t;
    typedef struct packed { logic [4:0] rd; logic [31:0] d; int cyc; } log_t;

    int checks = 0, errors = 0, cyc = 0;
    ent_t mq[$];
    logic m_we = 1'b0;
    logic [4:0] m_rd = '0;
    logic [31:0] m_wd = '0;
    log_t dlog[$];
    logic [31:0] drf [32];

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    function automatic ent_t mk(input int r, input logic [31:0] d);
        ent_t e;
        e.rd = r[4:0];
        e.d  = d;
        return e;
    endfunction

    // Reference model: ALU queue plus the priority rule, evaluated once per edge.
    initial begin
        forever begin
            @(posedge clk or negedge rst_n);
            if (!rst_n) begin
                mq.delete();
                m_we = 1'b0; m_rd = '0; m_wd = '0;
            end else begin
                bit full, sel;
                ent_t e;
                full = (mq.size() == DEPTH);
                sel  = 1'b1;
                e    = '0;
                if (full)                e = mq.pop_front();
                else if (mem_valid)      e = mk(int'(mem_rd), mem_data);
                else if (mq.size() > 0)  e = mq.pop_front();
                else                     sel = 1'b0;
                if (!full && alu_valid) mq.push_back(mk(int'(alu_rd), alu_data));
                if (sel) begin
                    m_we = (e.rd != 0); m_rd = e.rd; m_wd = e.d;
                end else begin
                    m_we = 1'b0;
                end
            end
        end
    end

    initial begin
        for (int i = 0; i < 32; i++) drf[i] = '0;
        forever begin
            @(negedge clk);
            cyc++;
            chk("fifo_count", 64'(fifo_count), 64'(mq.size()));
            chk("alu_ready", 64'(alu_ready), 64'(mq.size() < DEPTH));
            chk("mem_ready", 64'(mem_ready), 64'(mq.size() < DEPTH));
            chk("we", 64'(we), 64'(m_we));
            chk("rd", 64'(rd), 64'(m_rd));
            chk("wd", 64'(wd), 64'(m_wd));
            if (we) begin
                log_t l;
                l.rd = rd; l.d = wd; l.cyc = cyc;
                drf[rd] = wd;
                dlog.push_back(l);
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic idle();
        alu_valid = 1'b0;
        mem_valid = 1'b0;
    endtask

    task automatic set_alu(input int r, input logic [31:0] d);
        alu_valid = 1'b1; alu_rd = r[4:0]; alu_data = d;
    endtask

    task automatic set_mem(input int r, input logic [31:0] d);
        mem_valid = 1'b1; mem_rd = r[4:0]; mem_data = d;
    endtask

    task automatic expect_log(input string nm, input ent_t e[$]);
        chk({nm, "_nwrites"}, 64'(dlog.size()), 64'(e.size()));
        for (int i = 0; i < e.size() && i < dlog.size(); i++) begin
            chk({nm, "_rd"}, 64'(dlog[i].rd), 64'(e[i].rd));
            chk({nm, "_wd"}, 64'(dlog[i].d), 64'(e[i].d));
            if (i > 0) chk({nm, "_consecutive"}, 64'(dlog[i].cyc - dlog[i-1].cyc), 64'd1);
        end
    endtask

    initial begin
        ent_t ex[$];
        repeat (3) tick();
        chk("rst_we", 64'(we), 64'd0);
        chk("rst_rd", 64'(rd), 64'd0);
        chk("rst_wd", 64'(wd), 64'd0);
        chk("rst_count", 64'(fifo_count), 64'd0);
        chk("rst_alu_ready", 64'(alu_ready), 64'd1);
        chk("rst_mem_ready", 64'(mem_ready), 64'd1);
        rst_n = 1'b1;
        tick();
        chk("post_rst_we", 64'(we), 64'd0);

        // ALU only
        dlog.delete();
        set_alu(1, 67); tick();
        set_alu(3, 69); tick();
        idle(); repeat (3) tick();
        ex.delete(); ex.push_back(mk(1, 67)); ex.push_back(mk(3, 69));
        expect_log("alu_only", ex);
        chk("rf_x1", 64'(drf[1]), 64'd67);
        chk("rf_x3", 64'(drf[3]), 64'd69);

        // simultaneous alu + mem, load wins
        dlog.delete();
        set_alu(5, 10); set_mem(6, 20); tick();
        idle(); repeat (3) tick();
        ex.delete(); ex.push_back(mk(6, 20)); ex.push_back(mk(5, 10));
        expect_log("simul", ex);

        // full FIFO blocks the load until one entry drains
        dlog.delete();
        set_mem(10, 100); set_alu(7, 1); tick();
        set_mem(11, 101); set_alu(8, 2); tick();
        alu_valid = 1'b0; set_mem(12, 102);
        chk("full_count", 64'(fifo_count), 64'd2);
        chk("full_mem_ready", 64'(mem_ready), 64'd0);
        chk("full_alu_ready", 64'(alu_ready), 64'd0);
        tick();
        chk("drain_count", 64'(fifo_count), 64'd1);
        chk("drain_mem_ready", 64'(mem_ready), 64'd1);
        tick();
        idle(); repeat (3) tick();
        ex.delete();
        ex.push_back(mk(10, 100)); ex.push_back(mk(11, 101)); ex.push_back(mk(7, 1));
        ex.push_back(mk(12, 102)); ex.push_back(mk(8, 2));
        expect_log("full", ex);

        // x0 is consumed but never written
        dlog.delete();
        set_mem(0, 32'hDEADBEEF); tick();
        idle();
        chk("x0_we", 64'(we), 64'd0);
        repeat (2) tick();
        chk("x0_nwrites", 64'(dlog.size()), 64'd0);
        chk("x0_rf", 64'(drf[0]), 64'd0);

        // asynchronous reset with two queued ALU results
        set_mem(20, 1); set_alu(21, 2); tick();
        set_mem(22, 3); set_alu(23, 4); tick();
        idle();
        chk("pre_rst_count", 64'(fifo_count), 64'd2);
        #1 rst_n = 1'b0;
        #1;
        chk("async_rst_count", 64'(fifo_count), 64'd0);
        chk("async_rst_we", 64'(we), 64'd0);
        chk("async_rst_alu_ready", 64'(alu_ready), 64'd1);
        dlog.delete();
        repeat (2) tick();
        rst_n = 1'b1;
        repeat (4) tick();
        chk("no_stale_writes", 64'(dlog.size()), 64'd0);

        // pointer wrap: 10 back-to-back ALU results
        dlog.delete();
        ex.delete();
        for (int i = 0; i < 10; i++) begin
            set_alu(i + 1, 32'(1000 + i));
            ex.push_back(mk(i + 1, 32'(1000 + i)));
            tick();
        end
        idle(); repeat (3) tick();
        expect_log("wrap", ex);

        // random traffic, with one asynchronous reset in the middle
        for (int n = 0; n < 600; n++) begin
            alu_valid = 1'($urandom_range(0, 1));
            mem_valid = ($urandom_range(0, 2) == 0);
            alu_rd    = ($urandom_range(0, 7) == 0) ? 5'd0 : 5'($urandom_range(1, 31));
            mem_rd    = ($urandom_range(0, 7) == 0) ? 5'd0 : 5'($urandom_range(1, 31));
            alu_data  = $urandom;
            mem_data  = $urandom;
            if (n == 300) begin
                #1 rst_n = 1'b0;
                #2 rst_n = 1'b1;
            end
            tick();
        end
        idle(); repeat (4) tick();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/wb_arbiter.md
WB_ARBITER -- requirements
Module: wb_arbiter

Interface
REQ-001 Parameter XLEN, default 32, data width of results and of the register-file write data.
REQ-002 Parameter DEPTH, default 2, number of entries in the ALU result FIFO (power of two, at least 2).
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 rst_n  input  1  reset, asynchronous and active-low.
REQ-005 alu_valid  input  1  ALU result offered this cycle.
REQ-006 alu_ready  output  1  ALU result accepted when alu_valid and alu_ready are both 1.
REQ-007 alu_rd  input  5  ALU destination register index.
REQ-008 alu_data  input  XLEN  ALU result value.
REQ-009 mem_valid  input  1  load result offered this cycle.
REQ-010 mem_ready  output  1  load result accepted when mem_valid and mem_ready are both 1.
REQ-011 mem_rd  input  5  load destination register index.
REQ-012 mem_data  input  XLEN  load result value.
REQ-013 rd  output  5  register-file write index; drives regfile rd.
REQ-014 wd  output  XLEN  register-file write data; drives regfile wd.
REQ-015 we  output  1  register-file write enable; drives regfile we.
REQ-016 fifo_count  output  $clog2(DEPTH)+1  number of occupied ALU FIFO entries.

Function
- REQ-017 An accepted ALU result SHALL be pushed into the ALU FIFO in the same edge; results leave the FIFO in arrival order.
- REQ-018 alu_ready SHALL be 1 exactly when fifo_count < DEPTH; it SHALL be combinational from the FIFO count only, with no bypass from the input to the output path.
- REQ-019 Arbitration each cycle: if fifo_count == DEPTH, pop the FIFO head and hold mem_ready = 0; else if mem_valid, accept the load (mem priority); else if fifo_count > 0, pop the FIFO head; else select nothing.
- REQ-020 mem_ready SHALL be 1 exactly when fifo_count != DEPTH, independent of mem_valid.
- REQ-021 The selected result SHALL appear on rd/wd with we = 1 on the edge that consumes it (1-cycle latency, registered outputs).
- REQ-022 A selected result with index 0 SHALL be consumed, but we SHALL be 0 that cycle (x0 never written).
- REQ-023 When nothing is selected, we SHALL be 0; rd and wd SHALL hold their last values.
- REQ-024 A push and a pop in the same cycle SHALL leave fifo_count unchanged.
- REQ-025 FIFO read and write pointers SHALL wrap modulo DEPTH without loss or duplication.
- REQ-026 At most one register-file write SHALL occur per cycle; every accepted result SHALL be presented exactly once.

Reset
- REQ-027 While rst_n is 0: we = 0, rd = 0, wd = 0, FIFO empty, fifo_count = 0, alu_ready = 1, mem_ready = 1.
- REQ-028 Reset asserted mid-operation SHALL discard all queued ALU results immediately, without waiting for a clock edge.
- REQ-029 No write SHALL be issued on the first edge after rst_n rises unless a result is accepted on that edge.

Structure
- REQ-030 XLEN and the register index width (5) SHALL live in the shared package cpu_pkg.
- REQ-031 The FIFO SHALL be a sub-module named wb_fifo (parameters XLEN+5, DEPTH; push/pop/count ports).
- REQ-032 Arbitration and output registers SHALL reside in wb_arbiter itself.

Verification
- REQ-033 ALU only: alu rd=1 data=67, then rd=3 data=69 -> we=1 with (1,67), then (3,69) on consecutive cycles; regfile reads rs1=1 -> 67 and rs2=3 -> 69.
- REQ-034 Simultaneous: alu (5,10) and mem (6,20) in the same cycle, FIFO empty -> (6,20) written first, then (5,10) next cycle.
- REQ-035 FIFO full: mem_valid held at 1 while 2 ALU results are queued -> mem_ready=0, alu_ready=0; FIFO drains one entry; then the load is written.
- REQ-036 x0: mem (0,0xDEADBEEF) -> consumed, we=0; regfile x0 reads 0.
- REQ-037 Reset mid-stream: rst_n=0 with fifo_count=2 -> fifo_count=0, we=0 immediately; after release no stale write appears.
- REQ-038 Wrap: 10 back-to-back ALU results with mem idle -> all 10 written in order, none dropped or duplicated.
